// File: rtl/ysyx_25040129_xbar.sv
// ysyx_25040129_xbar
// AXI4-Lite address-decoding crossbar. It sits between the single LSU master
// and three slaves:
//   memory : full AXI4-Lite, 128 MiB window at MEM_BASE
//   CLINT  : read-only (AR+R), 64 KiB window at CLINT_BASE
//   UART   : write-only (AW+W+B), 4 KiB window at UART_BASE
// Each request is latched and routed by address. The response is registered
// back to the master. The read and write paths are independent, and each path
// allows one outstanding transaction.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   s_ar*/s_r*          master read address / read data
//   s_aw*/s_w*/s_b*     master write address / write data / write response
//   mem_*               memory slave, all five channels
//   clint_*             CLINT slave, AR+R only
//   uart_*              UART slave, AW+W+B only
//
// Build option YSYX_25040129_XBAR_DECERR_EN:
//   defined   - unmapped accesses are answered locally with resp 2'b11, rdata 0
//   undefined - unmapped accesses are routed to the memory port
module ysyx_25040129_xbar #(
   parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
   parameter logic [31:0] UART_BASE  = 32'h1000_0000,
   parameter logic [31:0] MEM_BASE   = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   // master read
   input  logic [31:0] s_araddr,
   input  logic        s_arvalid,
   output logic        s_arready,
   output logic [31:0] s_rdata,
   output logic [1:0]  s_rresp,
   output logic        s_rvalid,
   input  logic        s_rready,
   // master write
   input  logic [31:0] s_awaddr,
   input  logic        s_awvalid,
   output logic        s_awready,
   input  logic [31:0] s_wdata,
   input  logic [3:0]  s_wstrb,
   input  logic        s_wvalid,
   output logic        s_wready,
   output logic [1:0]  s_bresp,
   output logic        s_bvalid,
   input  logic        s_bready,
   // memory slave
   output logic [31:0] mem_araddr,
   output logic        mem_arvalid,
   input  logic        mem_arready,
   input  logic [31:0] mem_rdata,
   input  logic [1:0]  mem_rresp,
   input  logic        mem_rvalid,
   output logic        mem_rready,
   output logic [31:0] mem_awaddr,
   output logic        mem_awvalid,
   input  logic        mem_awready,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   output logic        mem_wvalid,
   input  logic        mem_wready,
   input  logic [1:0]  mem_bresp,
   input  logic        mem_bvalid,
   output logic        mem_bready,
   // CLINT slave
   output logic [31:0] clint_araddr,
   output logic        clint_arvalid,
   input  logic        clint_arready,
   input  logic [31:0] clint_rdata,
   input  logic [1:0]  clint_rresp,
   input  logic        clint_rvalid,
   output logic        clint_rready,
   // UART slave
   output logic [31:0] uart_awaddr,
   output logic        uart_awvalid,
   input  logic        uart_awready,
   output logic [31:0] uart_wdata,
   output logic [3:0]  uart_wstrb,
   output logic        uart_wvalid,
   input  logic        uart_wready,
   input  logic [1:0]  uart_bresp,
   input  logic        uart_bvalid,
   output logic        uart_bready
);

   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_RESP} rd_state_e;
   typedef enum logic [1:0] {W_IDLE, W_ADDR, W_BWAIT, W_RESP} wr_state_e;
   typedef enum logic [1:0] {T_MEM, T_CLINT, T_UART, T_NONE} tgt_e;

`ifdef YSYX_25040129_XBAR_DECERR_EN
   localparam tgt_e UNMAPPED_TGT = T_NONE;
`else
   localparam tgt_e UNMAPPED_TGT = T_MEM;
`endif

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   function automatic tgt_e decode(input logic [31:0] addr);
      tgt_e t;
      t = UNMAPPED_TGT;
      if (addr[31:27] == MEM_BASE[31:27])        t = T_MEM;
      else if (addr[31:16] == CLINT_BASE[31:16]) t = T_CLINT;
      else if (addr[31:12] == UART_BASE[31:12])  t = T_UART;
      return t;
   endfunction

   // ---------------------------------------------------------------- read path
   rd_state_e   rd_state_q, rd_state_d;
   tgt_e        rd_tgt_q, rd_tgt_d, rd_dec;
   logic [31:0] rd_addr_q, rd_addr_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  rresp_q, rresp_d;
   logic        rd_arvalid, rd_rready;
   logic        rd_is_clint;
   logic        rd_slv_arready, rd_slv_rvalid;
   logic [31:0] rd_slv_rdata;
   logic [1:0]  rd_slv_rresp;

   assign rd_dec      = decode(s_araddr);
   assign rd_is_clint = (rd_tgt_q == T_CLINT);

   // Only MEM or CLINT ever reach R_ADDR/R_DATA. Local answers skip those states.
   assign rd_slv_arready = rd_is_clint ? clint_arready : mem_arready;
   assign rd_slv_rvalid  = rd_is_clint ? clint_rvalid  : mem_rvalid;
   assign rd_slv_rdata   = rd_is_clint ? clint_rdata   : mem_rdata;
   assign rd_slv_rresp   = rd_is_clint ? clint_rresp   : mem_rresp;

   assign mem_araddr    = rd_addr_q;
   assign clint_araddr  = rd_addr_q;
   assign mem_arvalid   = rd_arvalid && !rd_is_clint;
   assign clint_arvalid = rd_arvalid &&  rd_is_clint;
   assign mem_rready    = rd_rready  && !rd_is_clint;
   assign clint_rready  = rd_rready  &&  rd_is_clint;

   assign s_rdata  = rdata_q;
   assign s_rresp  = rresp_q;
   assign s_rvalid = (rd_state_q == R_RESP);

   always_comb begin
      rd_state_d = rd_state_q;
      rd_tgt_d   = rd_tgt_q;
      rd_addr_d  = rd_addr_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      s_arready  = 1'b0;
      rd_arvalid = 1'b0;
      rd_rready  = 1'b0;
      unique case (rd_state_q)
         R_IDLE: begin
            s_arready = !rst;
            if (s_arvalid) begin
               rd_addr_d = s_araddr;
               rd_tgt_d  = rd_dec;
               case (rd_dec)
                  T_UART: begin
                     rdata_d    = '0;
                     rresp_d    = RESP_SLVERR;
                     rd_state_d = R_RESP;
                  end
                  T_NONE: begin
                     rdata_d    = '0;
                     rresp_d    = RESP_DECERR;
                     rd_state_d = R_RESP;
                  end
                  default: rd_state_d = R_ADDR;
               endcase
            end
         end
         R_ADDR: begin
            rd_arvalid = 1'b1;
            if (rd_slv_arready) rd_state_d = R_DATA;
         end
         R_DATA: begin
            rd_rready = 1'b1;
            if (rd_slv_rvalid) begin
               rdata_d    = rd_slv_rdata;
               rresp_d    = rd_slv_rresp;
               rd_state_d = R_RESP;
            end
         end
         R_RESP: begin
            if (s_rready) rd_state_d = R_IDLE;
         end
         default: rd_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_state_q <= R_IDLE;
         rd_tgt_q   <= T_MEM;
         rd_addr_q  <= '0;
         rdata_q    <= '0;
         rresp_q    <= RESP_OKAY;
      end else begin
         rd_state_q <= rd_state_d;
         rd_tgt_q   <= rd_tgt_d;
         rd_addr_q  <= rd_addr_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
      end
   end

   // --------------------------------------------------------------- write path
   wr_state_e   wr_state_q, wr_state_d;
   tgt_e        wr_tgt_q, wr_tgt_d, wr_dec;
   logic [31:0] wr_addr_q, wr_addr_d;
   logic [31:0] wr_data_q, wr_data_d;
   logic [3:0]  wr_strb_q, wr_strb_d;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q, w_done_d;
   logic [1:0]  bresp_q, bresp_d;
   logic        wr_awvalid, wr_wvalid, wr_bready;
   logic        wr_is_uart;
   logic        wr_slv_awready, wr_slv_wready, wr_slv_bvalid;
   logic [1:0]  wr_slv_bresp;

   assign wr_dec     = decode(s_awaddr);
   assign wr_is_uart = (wr_tgt_q == T_UART);

   assign wr_slv_awready = wr_is_uart ? uart_awready : mem_awready;
   assign wr_slv_wready  = wr_is_uart ? uart_wready  : mem_wready;
   assign wr_slv_bvalid  = wr_is_uart ? uart_bvalid  : mem_bvalid;
   assign wr_slv_bresp   = wr_is_uart ? uart_bresp   : mem_bresp;

   assign mem_awaddr   = wr_addr_q;
   assign uart_awaddr  = wr_addr_q;
   assign mem_wdata    = wr_data_q;
   assign uart_wdata   = wr_data_q;
   assign mem_wstrb    = wr_strb_q;
   assign uart_wstrb   = wr_strb_q;
   assign mem_awvalid  = wr_awvalid && !wr_is_uart;
   assign uart_awvalid = wr_awvalid &&  wr_is_uart;
   assign mem_wvalid   = wr_wvalid  && !wr_is_uart;
   assign uart_wvalid  = wr_wvalid  &&  wr_is_uart;
   assign mem_bready   = wr_bready  && !wr_is_uart;
   assign uart_bready  = wr_bready  &&  wr_is_uart;

   assign s_bresp  = bresp_q;
   assign s_bvalid = (wr_state_q == W_RESP);

   always_comb begin
      wr_state_d = wr_state_q;
      wr_tgt_d   = wr_tgt_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      wr_strb_d  = wr_strb_q;
      aw_done_d  = aw_done_q;
      w_done_d   = w_done_q;
      bresp_d    = bresp_q;
      s_awready  = 1'b0;
      s_wready   = 1'b0;
      wr_awvalid = 1'b0;
      wr_wvalid  = 1'b0;
      wr_bready  = 1'b0;
      unique case (wr_state_q)
         W_IDLE: begin
            // Address and data are accepted together, so the slave sees one whole request.
            s_awready = s_awvalid && s_wvalid && !rst;
            s_wready  = s_awvalid && s_wvalid && !rst;
            if (s_awvalid && s_wvalid) begin
               wr_addr_d = s_awaddr;
               wr_data_d = s_wdata;
               wr_strb_d = s_wstrb;
               wr_tgt_d  = wr_dec;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               case (wr_dec)
                  T_CLINT: begin
                     bresp_d    = RESP_SLVERR;
                     wr_state_d = W_RESP;
                  end
                  T_NONE: begin
                     bresp_d    = RESP_DECERR;
                     wr_state_d = W_RESP;
                  end
                  default: wr_state_d = W_ADDR;
               endcase
            end
         end
         W_ADDR: begin
            // AW and W can complete in different cycles. Each valid drops after its own handshake.
            wr_awvalid = !aw_done_q;
            wr_wvalid  = !w_done_q;
            aw_done_d  = aw_done_q || wr_slv_awready;
            w_done_d   = w_done_q  || wr_slv_wready;
            if (aw_done_d && w_done_d) wr_state_d = W_BWAIT;
         end
         W_BWAIT: begin
            wr_bready = 1'b1;
            if (wr_slv_bvalid) begin
               bresp_d    = wr_slv_bresp;
               wr_state_d = W_RESP;
            end
         end
         W_RESP: begin
            if (s_bready) wr_state_d = W_IDLE;
         end
         default: wr_state_d = W_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_state_q <= W_IDLE;
         wr_tgt_q   <= T_MEM;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         wr_strb_q  <= '0;
         aw_done_q  <= 1'b0;
         w_done_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
      end else begin
         wr_state_q <= wr_state_d;
         wr_tgt_q   <= wr_tgt_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         wr_strb_q  <= wr_strb_d;
         aw_done_q  <= aw_done_d;
         w_done_q   <= w_done_d;
         bresp_q    <= bresp_d;
      end
   end

endmodule

// File: tb/tb_ysyx_25040129_xbar.sv
// Directed testbench for ysyx_25040129_xbar. It applies a table of single
// read/write vectors and then runs hand-written sequences for the stall,
// concurrency and reset corner cases.
module tb_ysyx_25040129_xbar;

   localparam logic [31:0] CLINT_LO = 32'h1357_9BDF;
   localparam logic [31:0] MEM_XOR  = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] s_araddr, s_awaddr, s_wdata;
   logic        s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready;
   logic [3:0]  s_wstrb;
   logic        s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
   logic [31:0] s_rdata;
   logic [1:0]  s_rresp, s_bresp;

   logic [31:0] mem_araddr, mem_awaddr, mem_wdata, mem_rdata;
   logic        mem_arvalid, mem_rready, mem_awvalid, mem_wvalid, mem_bready;
   logic [3:0]  mem_wstrb;
   logic        mem_arready, mem_rvalid, mem_awready, mem_wready, mem_bvalid;
   logic [1:0]  mem_rresp, mem_bresp;

   logic [31:0] clint_araddr, clint_rdata;
   logic        clint_arvalid, clint_rready, clint_arready, clint_rvalid;
   logic [1:0]  clint_rresp;

   logic [31:0] uart_awaddr, uart_wdata;
   logic [3:0]  uart_wstrb;
   logic        uart_awvalid, uart_wvalid, uart_bready;
   logic        uart_awready, uart_wready, uart_bvalid;
   logic [1:0]  uart_bresp;

   // slave behaviour knobs
   logic mem_arready_v, mem_rvalid_v, clint_rvalid_v;

   always #5 clk = ~clk;

   // slave models
   assign mem_arready   = mem_arready_v;
   assign mem_rvalid    = mem_rvalid_v;
   assign mem_rdata     = mem_araddr ^ MEM_XOR;
   assign mem_rresp     = 2'b00;
   assign mem_awready   = 1'b1;
   assign mem_wready    = 1'b1;
   assign mem_bvalid    = 1'b1;
   assign mem_bresp     = 2'b10;
   assign clint_arready = 1'b1;
   assign clint_rvalid  = clint_rvalid_v;
   assign clint_rdata   = clint_araddr[2] ? 32'h0 : CLINT_LO;
   assign clint_rresp   = 2'b00;
   assign uart_awready  = 1'b1;
   assign uart_wready   = 1'b1;
   assign uart_bvalid   = 1'b1;
   assign uart_bresp    = 2'b00;

   ysyx_25040129_xbar #(
      .CLINT_BASE(32'h0200_0000),
      .UART_BASE (32'h1000_0000),
      .MEM_BASE  (32'h8000_0000)
   ) dut (
      .clk(clk), .rst(rst),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .mem_araddr(mem_araddr), .mem_arvalid(mem_arvalid), .mem_arready(mem_arready),
      .mem_rdata(mem_rdata), .mem_rresp(mem_rresp), .mem_rvalid(mem_rvalid), .mem_rready(mem_rready),
      .mem_awaddr(mem_awaddr), .mem_awvalid(mem_awvalid), .mem_awready(mem_awready),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
      .mem_bresp(mem_bresp), .mem_bvalid(mem_bvalid), .mem_bready(mem_bready),
      .clint_araddr(clint_araddr), .clint_arvalid(clint_arvalid), .clint_arready(clint_arready),
      .clint_rdata(clint_rdata), .clint_rresp(clint_rresp), .clint_rvalid(clint_rvalid),
      .clint_rready(clint_rready),
      .uart_awaddr(uart_awaddr), .uart_awvalid(uart_awvalid), .uart_awready(uart_awready),
      .uart_wdata(uart_wdata), .uart_wstrb(uart_wstrb), .uart_wvalid(uart_wvalid),
      .uart_wready(uart_wready), .uart_bresp(uart_bresp), .uart_bvalid(uart_bvalid),
      .uart_bready(uart_bready)
   );

   // slave-side activity monitor, sampled mid-cycle
   int          mem_cnt = 0, clint_cnt = 0, uart_aw_cnt = 0, uart_w_cnt = 0;
   logic [31:0] last_mem_araddr = '0, last_uart_wdata = '0;
   logic [3:0]  last_uart_wstrb = '0;
   always @(negedge clk) begin
      if (mem_arvalid) begin mem_cnt++; last_mem_araddr = mem_araddr; end
      if (mem_awvalid) mem_cnt++;
      if (clint_arvalid) clint_cnt++;
      if (uart_awvalid) uart_aw_cnt++;
      if (uart_wvalid) begin uart_w_cnt++; last_uart_wdata = uart_wdata; last_uart_wstrb = uart_wstrb; end
   end

   int n_cmp = 0, n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [1:0]  exp_resp;
      logic [31:0] exp_rdata;
      int          exp_lat;
      int          exp_mem;
      int          exp_clint;
      int          exp_uart;
   } vec_t;

   localparam int NV = 14;
   vec_t vecs [NV];

   // Issue one transaction from a negedge and return the response and its latency in cycles after the handshake.
   task automatic run_vec(input vec_t v, output logic [1:0] resp, output logic [31:0] data, output int lat);
      int n;
      lat  = -1;
      resp = 2'bxx;
      data = 'x;
      if (v.wr) begin
         s_awaddr = v.addr; s_wdata = v.wdata; s_wstrb = v.wstrb;
         s_awvalid = 1'b1; s_wvalid = 1'b1;
      end else begin
         s_araddr = v.addr; s_arvalid = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      s_arvalid = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
      n = 1;
      while (lat < 0 && n <= 20) begin
         if (v.wr ? s_bvalid : s_rvalid) begin
            lat  = n;
            resp = v.wr ? s_bresp : s_rresp;
            data = s_rdata;
         end else begin
            @(negedge clk);
            n++;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      logic [1:0]  resp;
      logic [31:0] data;
      int          lat, m0, c0, a0, w0;
      int          rv_at, bv_at;
      logic        ok;

      vecs[0]  = '{1'b0, 32'h0200_0000, 32'h0, 4'h0, 2'b00, CLINT_LO, 3, 0, 1, 0};
      vecs[1]  = '{1'b0, 32'h0200_0004, 32'h0, 4'h0, 2'b00, 32'h0, 3, 0, 1, 0};
      vecs[2]  = '{1'b1, 32'h1000_03F8, 32'h41, 4'b0001, 2'b00, 32'h0, 3, 0, 0, 1};
      vecs[3]  = '{1'b0, 32'h1000_0000, 32'h0, 4'h0, 2'b10, 32'h0, 1, 0, 0, 0};
      vecs[4]  = '{1'b1, 32'h0200_0000, 32'h5, 4'hF, 2'b10, 32'h0, 1, 0, 0, 0};
      vecs[5]  = '{1'b0, 32'h8000_0010, 32'h0, 4'h0, 2'b00, 32'h8000_0010 ^ MEM_XOR, 3, 1, 0, 0};
      vecs[6]  = '{1'b1, 32'h8000_0020, 32'h99, 4'hF, 2'b10, 32'h0, 3, 1, 0, 0};
`ifdef YSYX_25040129_XBAR_DECERR_EN
      vecs[7]  = '{1'b0, 32'h3000_0000, 32'h0, 4'h0, 2'b11, 32'h0, 1, 0, 0, 0};
      vecs[8]  = '{1'b1, 32'h3000_0000, 32'h7, 4'hF, 2'b11, 32'h0, 1, 0, 0, 0};
      vecs[12] = '{1'b0, 32'h8800_0000, 32'h0, 4'h0, 2'b11, 32'h0, 1, 0, 0, 0};
`else
      vecs[7]  = '{1'b0, 32'h3000_0000, 32'h0, 4'h0, 2'b00, 32'h3000_0000 ^ MEM_XOR, 3, 1, 0, 0};
      vecs[8]  = '{1'b1, 32'h3000_0000, 32'h7, 4'hF, 2'b10, 32'h0, 3, 1, 0, 0};
      vecs[12] = '{1'b0, 32'h8800_0000, 32'h0, 4'h0, 2'b00, 32'h8800_0000 ^ MEM_XOR, 3, 1, 0, 0};
`endif
      vecs[9]  = '{1'b0, 32'h1000_0FFC, 32'h0, 4'h0, 2'b10, 32'h0, 1, 0, 0, 0};
      vecs[10] = '{1'b0, 32'h87FF_FFFC, 32'h0, 4'h0, 2'b00, 32'h87FF_FFFC ^ MEM_XOR, 3, 1, 0, 0};
      vecs[11] = '{1'b1, 32'h0200_FFFC, 32'h1, 4'h1, 2'b10, 32'h0, 1, 0, 0, 0};
      vecs[13] = '{1'b1, 32'h1000_0FF0, 32'hAB, 4'b1111, 2'b00, 32'h0, 3, 0, 0, 1};

      // Drive valids during reset: no ready may be raised while rst is high.
      rst = 1'b1;
      s_araddr = 32'h8000_0000; s_awaddr = 32'h8000_0000; s_wdata = '0; s_wstrb = '0;
      s_arvalid = 1'b1; s_awvalid = 1'b1; s_wvalid = 1'b1;
      s_rready = 1'b1; s_bready = 1'b1;
      mem_arready_v = 1'b1; mem_rvalid_v = 1'b1; clint_rvalid_v = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_arready", 32'(s_arready), 32'd0);
      chk("rst_awready", 32'(s_awready), 32'd0);
      chk("rst_wready", 32'(s_wready), 32'd0);
      chk("rst_rvalid", 32'(s_rvalid), 32'd0);
      chk("rst_bvalid", 32'(s_bvalid), 32'd0);
      chk("rst_rdata", s_rdata, 32'd0);
      chk("rst_resps", {28'd0, s_rresp, s_bresp}, 32'd0);
      chk("rst_slave_valids", {27'd0, mem_arvalid, mem_awvalid, clint_arvalid, uart_awvalid, uart_wvalid}, 32'd0);
      s_arvalid = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (100) @(negedge clk);
      chk("idle_arready", 32'(s_arready), 32'd1);

      for (int i = 0; i < NV; i++) begin
         m0 = mem_cnt; c0 = clint_cnt; a0 = uart_aw_cnt; w0 = uart_w_cnt;
         run_vec(vecs[i], resp, data, lat);
         chk($sformatf("v%0d_resp", i), 32'(resp), 32'(vecs[i].exp_resp));
         chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
         chk($sformatf("v%0d_mem_valid_cycles", i), 32'(mem_cnt - m0), 32'(vecs[i].exp_mem));
         chk($sformatf("v%0d_clint_valid_cycles", i), 32'(clint_cnt - c0), 32'(vecs[i].exp_clint));
         chk($sformatf("v%0d_uart_aw_cycles", i), 32'(uart_aw_cnt - a0), 32'(vecs[i].exp_uart));
         chk($sformatf("v%0d_uart_w_cycles", i), 32'(uart_w_cnt - w0), 32'(vecs[i].exp_uart));
         if (!vecs[i].wr)
            chk($sformatf("v%0d_rdata", i), data, vecs[i].exp_rdata);
         if (!vecs[i].wr && vecs[i].exp_mem > 0)
            chk($sformatf("v%0d_mem_araddr", i), last_mem_araddr, vecs[i].addr);
         if (vecs[i].wr && vecs[i].exp_uart > 0) begin
            chk($sformatf("v%0d_uart_wdata", i), last_uart_wdata, vecs[i].wdata);
            chk($sformatf("v%0d_uart_wstrb", i), 32'(last_uart_wstrb), 32'(vecs[i].wstrb));
         end
      end

      // CLINT stalls rvalid: the address must stay put and the master must see nothing until capture.
      clint_rvalid_v = 1'b0;
      s_araddr = 32'h0200_0004; s_arvalid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      s_arvalid = 1'b0;
      ok = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         if (clint_araddr !== 32'h0200_0004 || s_rvalid !== 1'b0) ok = 1'b0;
         if (k < 5) @(negedge clk);
      end
      chk("clint_stall_addr_hold", 32'(ok), 32'd1);
      clint_rvalid_v = 1'b1;
      lat = -1;
      for (int k = 1; k <= 10 && lat < 0; k++) begin
         @(negedge clk);
         if (s_rvalid) lat = k;
      end
      chk("clint_stall_release_latency", 32'(lat), 32'd1);
      chk("clint_stall_rdata_hi", s_rdata, 32'h0);
      chk("clint_stall_rresp", 32'(s_rresp), 32'd0);
      @(negedge clk);

      // Concurrent CLINT read and UART write: neither delays the other.
      s_araddr = 32'h0200_0000; s_arvalid = 1'b1;
      s_awaddr = 32'h1000_0000; s_wdata = 32'h5A; s_wstrb = 4'b0001;
      s_awvalid = 1'b1; s_wvalid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      s_arvalid = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
      rv_at = -1; bv_at = -1;
      for (int k = 1; k <= 10; k++) begin
         if (s_rvalid && rv_at < 0) rv_at = k;
         if (s_bvalid && bv_at < 0) bv_at = k;
         @(negedge clk);
      end
      chk("concurrent_read_latency", 32'(rv_at), 32'd3);
      chk("concurrent_write_latency", 32'(bv_at), 32'd3);

      // Memory read: arready held low for 5 cycles, then reset pulsed while in R_DATA.
      mem_arready_v = 1'b0; mem_rvalid_v = 1'b0;
      s_araddr = 32'h8000_0100; s_arvalid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      s_arvalid = 1'b0;
      ok = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         if (mem_arvalid !== 1'b1 || mem_araddr !== 32'h8000_0100) ok = 1'b0;
         if (k < 5) @(negedge clk);
      end
      chk("mem_stall_arvalid_held", 32'(ok), 32'd1);
      mem_arready_v = 1'b1;
      @(negedge clk);
      chk("mem_rdata_phase_rready", {30'd0, mem_rready, mem_arvalid}, 32'b10);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_arready", 32'(s_arready), 32'd0);
      rst = 1'b0;
      mem_rvalid_v = 1'b1;
      @(negedge clk);
      chk("post_rst_arready", 32'(s_arready), 32'd1);
      ok = 1'b1;
      for (int k = 0; k < 5; k++) begin
         if (s_rvalid !== 1'b0 || mem_arvalid !== 1'b0) ok = 1'b0;
         @(negedge clk);
      end
      chk("post_rst_no_response", 32'(ok), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
